// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared types and widths for the shift scheduler
package alu_pkg;

  localparam int OPW       = 4;
  localparam int RESW      = 8;
  localparam int CNTW      = 4;
  localparam int SHIFT_MAX = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/alu_shift_sched_if.sv
// rtl/alu_shift_sched_if.sv - requester/response bundle for the shift scheduler
interface alu_shift_sched_if;
  import alu_pkg::*;

  logic            req0_valid;
  logic [OPW-1:0]  req0_a;
  logic [OPW-1:0]  req0_b;
  logic            req0_ready;
  logic            req1_valid;
  logic [OPW-1:0]  req1_a;
  logic [OPW-1:0]  req1_b;
  logic            req1_ready;
  logic            rsp_valid;
  logic [RESW-1:0] rsp_data;
  logic            rsp_id;
  logic            rsp_ready;
  logic            busy;

  modport master (
    output req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, rsp_ready,
    input  req0_ready, req1_ready, rsp_valid, rsp_data, rsp_id, busy
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, rsp_ready,
    output req0_ready, req1_ready, rsp_valid, rsp_data, rsp_id, busy
  );

endinterface

// File: rtl/alu_rr_arbiter2.sv
// rtl/alu_rr_arbiter2.sv - two-way round-robin grant, one-hot output
module alu_rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] gnt
);

  // On contention the requester that did not win last time gets the grant.
  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = last_grant ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/alu_shift_sched.sv
// rtl/alu_shift_sched.sv - arbitrated serial shifter, one operation in flight
module alu_shift_sched #(
  parameter int SHIFT_MAX = alu_pkg::SHIFT_MAX
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req0_valid,
  input  logic [alu_pkg::OPW-1:0]  req0_a,
  input  logic [alu_pkg::OPW-1:0]  req0_b,
  output logic                     req0_ready,
  input  logic                     req1_valid,
  input  logic [alu_pkg::OPW-1:0]  req1_a,
  input  logic [alu_pkg::OPW-1:0]  req1_b,
  output logic                     req1_ready,
  output logic                     rsp_valid,
  output logic [alu_pkg::RESW-1:0] rsp_data,
  output logic                     rsp_id,
  input  logic                     rsp_ready,
  output logic                     busy
);
  import alu_pkg::*;

  localparam logic [CNTW-1:0] CNT_MAX = CNTW'(SHIFT_MAX);

  state_e          state_q, state_d;
  logic [RESW-1:0] acc_q, acc_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            id_q, id_d;
  logic            last_q, last_d;
  logic [RESW-1:0] rsp_data_q, rsp_data_d;
  logic            rsp_id_q, rsp_id_d;

  logic [1:0]      arb_req;
  logic [1:0]      gnt;
  logic [OPW-1:0]  a_sel;
  logic [OPW-1:0]  b_sel;

  // Requests are only visible to the arbiter while idle and out of reset.
  assign arb_req = {req1_valid, req0_valid} & {2{(state_q == ST_IDLE) && rst_n}};

  alu_rr_arbiter2 u_arb (
    .req        (arb_req),
    .last_grant (last_q),
    .gnt        (gnt)
  );

  assign req0_ready = gnt[0];
  assign req1_ready = gnt[1];
  assign a_sel      = gnt[1] ? req1_a : req0_a;
  assign b_sel      = gnt[1] ? req1_b : req0_b;

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    id_d       = id_q;
    last_d     = last_q;
    rsp_data_d = rsp_data_q;
    rsp_id_d   = rsp_id_q;
    case (state_q)
      ST_IDLE: begin
        if (gnt != 2'b00) begin
          acc_d   = {{(RESW-OPW){1'b0}}, a_sel};
          cnt_d   = (CNTW'(b_sel) > CNT_MAX) ? CNT_MAX : CNTW'(b_sel);
          id_d    = gnt[1];
          last_d  = gnt[1];
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (cnt_q != '0) begin
          acc_d = acc_q << 1;
          cnt_d = cnt_q - 1'b1;
        end else begin
          // Response registers only change here, so they hold the last result otherwise.
          rsp_data_d = acc_q;
          rsp_id_d   = id_q;
          state_d    = ST_DONE;
        end
      end
      ST_DONE: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      acc_q      <= '0;
      cnt_q      <= '0;
      id_q       <= 1'b0;
      last_q     <= 1'b1;
      rsp_data_q <= '0;
      rsp_id_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      id_q       <= id_d;
      last_q     <= last_d;
      rsp_data_q <= rsp_data_d;
      rsp_id_q   <= rsp_id_d;
    end
  end

  assign rsp_valid = (state_q == ST_DONE);
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;
  assign busy      = (state_q != ST_IDLE);

endmodule
